// File: rtl/fdma_pkg.sv
// Shared definitions for the FDMA frame-buffer scheduler.
// Holds the side-FSM state encoding and the buffer index and address helpers.
package fdma_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t BUSY  = 2'd2;

  // Modulo-n step by compare-and-subtract.
  // This is valid because idx < n and step <= 2 <= n, so one subtract always suffices.
  function automatic logic [1:0] buf_next(input logic [1:0] idx,
                                          input logic [1:0] step,
                                          input logic [2:0] n);
    logic [2:0] s;
    s = {1'b0, idx} + {1'b0, step};
    if (s >= n) s = s - n;
    return s[1:0];
  endfunction

  // Wide result; callers keep the low ADDR_W bits, so any wrap is ignored.
  function automatic logic [63:0] buf_addr(input logic [1:0]  idx,
                                           input logic [63:0] base = 64'h0,
                                           input logic [63:0] size = 64'h0020_0000);
    return base + ({62'b0, idx} * size);
  endfunction

endpackage

// File: rtl/fdma_side_fsm.sv
// One side (write or read) of the scheduler: IDLE -> START -> BUSY.
// Start is high for exactly the START cycle. Overflow is a registered one-cycle pulse.
module fdma_side_fsm
  import fdma_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fs,
  input  logic done,
  input  logic allow,
  output logic start,
  output logic acc,
  output logic done_acc,
  output logic ovf
);

  state_t state, state_n;
  logic   ovf_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n  = state;
    acc      = 1'b0;
    done_acc = 1'b0;
    ovf_n    = 1'b0;
    case (state)
      IDLE: begin
        // An fs that is not allowed is consumed here without a start.
        if (fs && allow) begin
          acc     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        state_n = BUSY;
        ovf_n   = fs;
      end
      BUSY: begin
        if (done) begin
          done_acc = 1'b1;
          if (fs && allow) begin
            acc     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          ovf_n = fs;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign start = (state == START);

endmodule

// File: rtl/fdma_buf_sched.sv
// Frame-buffer scheduler: picks the DDR buffer for each FDMA engine so the reader never sees a buffer being written.
// Index and address are registered and update one cycle after an accepted fs.
module fdma_buf_sched
  import fdma_pkg::*;
#(
  parameter int                BUF_NUM    = 3,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(32'h0020_0000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_fs_i,
  input  logic              rd_fs_i,
  input  logic              wr_done_i,
  input  logic              rd_done_i,
  output logic              wr_start_o,
  output logic [1:0]        wr_buf_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              rd_start_o,
  output logic [1:0]        rd_buf_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_valid_o,
  output logic              wr_ovf_o,
  output logic              rd_ovf_o
);

  localparam logic [2:0]        NB       = 3'(BUF_NUM);
  localparam logic [1:0]        WR_RST   = 2'(BUF_NUM - 1);
  localparam logic [63:0]       BASE64   = 64'(BASE_ADDR);
  localparam logic [63:0]       SIZE64   = 64'(FRAME_SIZE);
  localparam logic [ADDR_W-1:0] WR_RST_A = ADDR_W'(buf_addr(WR_RST, BASE64, SIZE64));
  localparam logic [ADDR_W-1:0] RD_RST_A = ADDR_W'(buf_addr(2'd0, BASE64, SIZE64));

  logic       wr_go, wr_done_acc, rd_go, rd_done_acc, rd_allow;
  logic [1:0] last_done, last_done_n;
  logic       new_frame, new_frame_n;
  logic [1:0] rd_sel, rd_eff, wr_cand, wr_sel;

  assign rd_allow = new_frame | rd_valid_o;

  fdma_side_fsm u_wr (
    .clk(clk_i), .rst(rst_i), .fs(wr_fs_i), .done(wr_done_i), .allow(1'b1),
    .start(wr_start_o), .acc(wr_go), .done_acc(wr_done_acc), .ovf(wr_ovf_o)
  );

  fdma_side_fsm u_rd (
    .clk(clk_i), .rst(rst_i), .fs(rd_fs_i), .done(rd_done_i), .allow(rd_allow),
    .start(rd_start_o), .acc(rd_go), .done_acc(rd_done_acc), .ovf(rd_ovf_o)
  );

  always_comb begin
    rd_sel  = new_frame ? last_done : rd_buf_o;
    rd_eff  = rd_go ? rd_sel : rd_buf_o;
    wr_cand = buf_next(wr_buf_o, 2'd1, NB);
    wr_sel  = (rd_valid_o && wr_cand == rd_eff) ? buf_next(wr_buf_o, 2'd2, NB) : wr_cand;

    // Read selection sees the pre-cycle bookkeeping; a same-cycle wr_done wins for the next rd_fs.
    last_done_n = wr_done_acc ? wr_buf_o : last_done;
    new_frame_n = new_frame;
    if (rd_go && new_frame) new_frame_n = 1'b0;
    if (wr_done_acc)        new_frame_n = 1'b1;
    if (wr_go && wr_sel == last_done_n) new_frame_n = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_buf_o   <= WR_RST;
      wr_addr_o  <= WR_RST_A;
      rd_buf_o   <= 2'd0;
      rd_addr_o  <= RD_RST_A;
      rd_valid_o <= 1'b0;
      last_done  <= 2'd0;
      new_frame  <= 1'b0;
    end else begin
      last_done <= last_done_n;
      new_frame <= new_frame_n;
      if (wr_go) begin
        wr_buf_o  <= wr_sel;
        wr_addr_o <= ADDR_W'(buf_addr(wr_sel, BASE64, SIZE64));
      end
      if (rd_go) begin
        rd_buf_o  <= rd_sel;
        rd_addr_o <= ADDR_W'(buf_addr(rd_sel, BASE64, SIZE64));
        if (new_frame) rd_valid_o <= 1'b1;
      end
    end
  end

  // rd_done_acc is not needed for index selection; the read FSM alone tracks completion.
  logic unused;
  assign unused = rd_done_acc;

endmodule

// File: tb/tb_fdma_buf_sched.sv
// Directed bench for fdma_buf_sched with BUF_NUM=3 and default addresses.
module tb_fdma_buf_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_fs = 1'b0, rd_fs = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
  logic        wr_start, rd_start, rd_valid, wr_ovf, rd_ovf;
  logic [1:0]  wr_buf, rd_buf;
  logic [31:0] wr_addr, rd_addr;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] A0 = 32'h0000_0000;
  localparam logic [31:0] A1 = 32'h0020_0000;
  localparam logic [31:0] A2 = 32'h0040_0000;

  fdma_buf_sched dut (
    .clk_i(clk), .rst_i(rst),
    .wr_fs_i(wr_fs), .rd_fs_i(rd_fs), .wr_done_i(wr_done), .rd_done_i(rd_done),
    .wr_start_o(wr_start), .wr_buf_o(wr_buf), .wr_addr_o(wr_addr),
    .rd_start_o(rd_start), .rd_buf_o(rd_buf), .rd_addr_o(rd_addr),
    .rd_valid_o(rd_valid), .wr_ovf_o(wr_ovf), .rd_ovf_o(rd_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: whatever is on the inputs is sampled at the next edge, then the inputs return low.
  task automatic step(input logic wf, input logic wd, input logic rf, input logic rd);
    wr_fs = wf; wr_done = wd; rd_fs = rf; rd_done = rd;
    @(posedge clk); #1;
    wr_fs = 1'b0; wr_done = 1'b0; rd_fs = 1'b0; rd_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  always @(negedge clk)
    if (!rst && wr_start && rd_valid) chk("wr_ne_rd", {31'b0, wr_buf != rd_buf}, 32'd1);

  logic [1:0] exp_wr [4] = '{2'd0, 2'd2, 2'd0, 2'd1};
  logic [1:0] exp_rd [4] = '{2'd0, 2'd1, 2'd0, 2'd2};

  initial begin
    #12;
    chk("rst_wr_buf", wr_buf, 2);
    chk("rst_wr_addr", wr_addr, A2);
    chk("rst_rd_buf", rd_buf, 0);
    chk("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    step(0, 0, 1, 0);
    chk("nofr_rd_start", rd_start, 0);
    chk("nofr_rd_valid", rd_valid, 0);
    chk("nofr_rd_buf", rd_buf, 0);

    step(1, 0, 0, 0);
    chk("w1_start", wr_start, 1);
    chk("w1_buf", wr_buf, 0);
    chk("w1_addr", wr_addr, A0);
    idle(1);
    chk("w1_start_one", wr_start, 0);
    idle(9);
    step(0, 1, 0, 0);
    chk("w1_done_nostart", wr_start, 0);

    step(0, 0, 1, 0);
    chk("r1_start", rd_start, 1);
    chk("r1_buf", rd_buf, 0);
    chk("r1_addr", rd_addr, A0);
    chk("r1_valid", rd_valid, 1);
    idle(2);
    step(0, 0, 0, 1);

    step(1, 0, 0, 0);
    chk("w2_buf", wr_buf, 1);
    chk("w2_addr", wr_addr, A1);
    idle(2);
    step(1, 0, 0, 0);
    chk("ovf_pulse", wr_ovf, 1);
    chk("ovf_nostart", wr_start, 0);
    chk("ovf_buf_kept", wr_buf, 1);
    idle(1);
    chk("ovf_one", wr_ovf, 0);
    step(1, 1, 0, 0);
    chk("wfd_no_ovf", wr_ovf, 0);
    chk("wfd_start", wr_start, 1);
    chk("wfd_buf", wr_buf, 2);
    chk("wfd_addr", wr_addr, A2);
    idle(2);

    step(0, 0, 1, 0);
    chk("r2_buf", rd_buf, 1);
    idle(2);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("rep_start", rd_start, 1);
    chk("rep_buf", rd_buf, 1);
    idle(2);

    step(1, 1, 0, 0);
    chk("pre_skip_buf", wr_buf, 0);
    idle(2);
    step(1, 1, 1, 0);
    chk("skip_buf", wr_buf, 2);
    chk("skip_addr", wr_addr, A2);
    chk("skip_rd_ovf", rd_ovf, 1);
    chk("skip_rd_buf", rd_buf, 1);
    idle(2);

    step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    chk("sim_rd_buf", rd_buf, 0);
    chk("sim_wr_buf", wr_buf, 1);
    chk("sim_wr_addr", wr_addr, A1);
    idle(2);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("sim_next_rd", rd_buf, 2);
    idle(2);

    // Writer at twice the reader rate.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, i[0], i[0]);
      chk($sformatf("fast_wr_%0d", i), wr_buf, exp_wr[i]);
      if (i[0]) chk($sformatf("fast_rd_%0d", i), rd_buf, exp_rd[i]);
      idle(2);
    end

    step(1, 1, 0, 0);
    chk("prerst_buf", wr_buf, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_wr_start", wr_start, 0);
    chk("arst_wr_buf", wr_buf, 2);
    chk("arst_wr_addr", wr_addr, A2);
    chk("arst_rd_buf", rd_buf, 0);
    chk("arst_rd_addr", rd_addr, A0);
    chk("arst_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    step(0, 1, 0, 0);
    chk("stray_done_start", wr_start, 0);
    chk("stray_done_buf", wr_buf, 2);
    step(0, 0, 1, 0);
    chk("stray_rd_start", rd_start, 0);
    chk("stray_rd_valid", rd_valid, 0);
    step(1, 0, 0, 0);
    chk("post_rst_buf", wr_buf, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fdma_buf_sched.md
Name: fdma_buf_sched

Overview:
- Frame-buffer scheduler for the FDMA multi-buffer video path.
- Takes one-cycle frame-start pulses from the write-side and read-side frame-sync capture blocks, plus per-frame done strobes from the FDMA write and read engines.
- Picks which DDR frame buffer each engine uses. It issues start pulses with the buffer base address, so the reader never sees a buffer the writer is currently filling (BUF_NUM ≥ 3).

Parameters:
- BUF_NUM, 3: number of frame buffers. Legal values are 2, 3 and 4.
- ADDR_W, 32: address width.
- BASE_ADDR, 32'h0000_0000: byte address of buffer 0.
- FRAME_SIZE, 32'h0020_0000: byte stride between buffers.

Ports:
- clk_i  in  1  single system clock; all logic is on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wr_fs_i  in  1  write-side frame-start pulse, one clk_i cycle.
- rd_fs_i  in  1  read-side frame-start pulse, one clk_i cycle.
- wr_done_i  in  1  write engine has finished the current frame, one-cycle strobe.
- rd_done_i  in  1  read engine has finished the current frame, one-cycle strobe.
- wr_start_o  out  1  write-frame start pulse.
- wr_buf_o  out  2  write buffer index.
- wr_addr_o  out  ADDR_W  write buffer base address.
- rd_start_o  out  1  read-frame start pulse.
- rd_buf_o  out  2  read buffer index.
- rd_addr_o  out  ADDR_W  read buffer base address.
- rd_valid_o  out  1  at least one complete frame has been handed to the reader since reset.
- wr_ovf_o  out  1  one-cycle pulse when wr_fs_i arrives while the write side is busy.
- rd_ovf_o  out  1  one-cycle pulse when rd_fs_i arrives while the read side is busy.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - both side FSMs go to IDLE;
  - wr_buf_o = BUF_NUM-1, rd_buf_o = 0;
  - last_done = 0, new_frame = 0, rd_valid_o = 0;
  - all pulses = 0;
  - addresses are recomputed from the reset indices.
- Reset mid-frame discards all state. No done strobe is expected afterwards; any that arrives in IDLE is ignored.
- Each side has its own FSM with states IDLE, START and BUSY:
  - IDLE --fs--> START;
  - START --> BUSY unconditionally; the start pulse is high during START only, exactly one cycle;
  - BUSY --done--> IDLE;
  - BUSY with done and fs in the same cycle --> START. The current frame is completed and the new one accepted. No overflow is flagged.
  - BUSY with fs but no done: the fs is dropped, the overflow output pulses for 1 cycle, and the state stays BUSY.
- Latency: an fs accepted at cycle n updates the index and address, and asserts the start pulse, at cycle n+1.
- Index and address outputs are registered. addr = BASE_ADDR + buf × FRAME_SIZE, computed in ADDR_W-bit arithmetic with wrap ignored. Addresses are stable from the start pulse until the next accepted fs.
- Write-index selection, on an accepted wr_fs:
  - cand = (wr_buf+1) mod BUF_NUM;
  - if rd_valid_o and cand == rd_buf_eff, use (wr_buf+2) mod BUF_NUM instead.
  - rd_buf_eff is the read index chosen in the same cycle when rd_fs is accepted simultaneously; otherwise it is the current rd_buf_o.
- When wr_done_i is accepted: last_done <= wr_buf_o and new_frame <= 1.
- If a write starts on the buffer equal to last_done (possible only with BUF_NUM=2), new_frame <= 0. The reader then does not jump onto a buffer being overwritten.
- Read-index selection, on an accepted rd_fs:
  - if new_frame: rd_buf <= last_done, new_frame <= 0, rd_valid_o <= 1, and rd_start_o pulses;
  - else if rd_valid_o: rd_buf is unchanged (repeat the last frame) and rd_start_o pulses;
  - else the fs is consumed with no start, and the FSM stays IDLE.
- Simultaneous events in one cycle:
  - the read selection uses last_done and new_frame as they were before the cycle;
  - a wr_done in that same cycle sets new_frame for the next rd_fs.
- Modulo arithmetic for BUF_NUM=3 uses a compare-and-subtract, not a divider.

Decomposition:
- Shared package fdma_pkg holds:
  - localparams for the FSM state encoding (IDLE=2'd0, START=2'd1, BUSY=2'd2);
  - function buf_next(idx, step, n);
  - function buf_addr(idx).
- One sub-module, fdma_side_fsm, is instantiated twice (write and read sides). It handles fs, done, busy, overflow and the start pulse, and emits an accept strobe to the top, where index selection lives.

Test Plan:
- Reset, then rd_fs with no prior write -> no rd_start_o; rd_valid_o=0, rd_buf_o=0.
- wr_fs, then 10 cycles later wr_done -> wr_start_o one cycle later with wr_buf_o=0 and wr_addr_o=0x0. Then rd_fs -> rd_buf_o=0, rd_addr_o=0x0, rd_valid_o=1.
- BUF_NUM=3, writer twice as fast as reader (4 write frames per 2 read frames) -> wr_buf_o never equals rd_buf_o at any wr_start_o. Reader always gets the latest last_done.
- wr_fs while BUSY without done -> wr_ovf_o high 1 cycle, wr_buf_o unchanged. wr_fs and wr_done in the same cycle -> no ovf, new wr_start_o next cycle.
- rd_fs twice with no intervening wr_done -> second rd_start_o repeats the same rd_buf_o. rd_fs and wr_fs in the same cycle with rd_buf_o=1, wr_buf_o=0 -> wr_buf_o skips to 2.
- rst_i asserted mid-BUSY on both sides -> outputs return to reset values asynchronously (before the next clk_i edge). A stray wr_done_i after release is ignored.
